// File: rtl/bus_wait_state_gen.sv
// Programmable READY wait-state generator for an 8088 minimum-mode bus.
// The target is latched on ALE; READY is held low for that device's wait count.
module bus_wait_state_gen #(
  parameter int WAIT_M0      = 0,
  parameter int WAIT_M1      = 2,
  parameter int WAIT_IO0     = 1,
  parameter int WAIT_IO1     = 3,
  parameter int DEFAULT_WAIT = 0,
  parameter int CNT_WIDTH    = 4
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        ALE,
  input  logic [3:0]  CS,
  input  logic        STAT_CLR,
  output logic        READY,
  output logic        WAIT_ACTIVE,
  output logic [2:0]  DEV_SEL,
  output logic [15:0] STAT_WAITS
);

  localparam int NUM_CS = 4;
  localparam logic [2:0] DEV_NONE = 3'd4;

  typedef logic [CNT_WIDTH-1:0] cnt_t;

  typedef struct packed {
    logic [2:0] dev;
    cnt_t       cnt;
  } tgt_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WAIT
  } state_t;

  localparam logic [NUM_CS-1:0][CNT_WIDTH-1:0] WAIT_TBL = {
    cnt_t'(WAIT_IO1), cnt_t'(WAIT_IO0), cnt_t'(WAIT_M1), cnt_t'(WAIT_M0)
  };

  state_t      state, state_n;
  cnt_t        cnt, cnt_n;
  logic [2:0]  dev_n;
  logic        ready_n;
  logic        inc;
  tgt_t        cap;

  // Lowest set chip select wins; scan from the top so the lowest index lands last.
  always_comb begin
    cap.dev = DEV_NONE;
    cap.cnt = cnt_t'(DEFAULT_WAIT);
    for (int i = NUM_CS-1; i >= 0; i--) begin
      if (CS[i]) begin
        cap.dev = 3'(i);
        cap.cnt = WAIT_TBL[i[1:0]];
      end
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dev_n   = DEV_SEL;
    ready_n = READY;
    inc     = 1'b0;
    if (ALE) begin
      // A capture restarts the cycle; READY is only released here if this
      // edge was already the last wait clock of the previous cycle.
      state_n = ST_ADDR;
      cnt_n   = cap.cnt;
      dev_n   = cap.dev;
      if (state == ST_WAIT && cnt == cnt_t'(1)) ready_n = 1'b1;
    end else begin
      case (state)
        ST_ADDR: begin
          if (cnt == '0) begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
          end else begin
            state_n = ST_WAIT;
            ready_n = 1'b0;
          end
        end
        ST_WAIT: begin
          inc   = 1'b1;
          cnt_n = cnt - cnt_t'(1);
          if (cnt == cnt_t'(1)) begin
            state_n = ST_IDLE;
            ready_n = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state       <= ST_IDLE;
      cnt         <= '0;
      DEV_SEL     <= DEV_NONE;
      READY       <= 1'b1;
      WAIT_ACTIVE <= 1'b0;
    end else begin
      state       <= state_n;
      cnt         <= cnt_n;
      DEV_SEL     <= dev_n;
      READY       <= ready_n;
      WAIT_ACTIVE <= ~ready_n;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)                            STAT_WAITS <= '0;
    else if (STAT_CLR)                       STAT_WAITS <= '0;
    else if (inc && STAT_WAITS != 16'hFFFF)  STAT_WAITS <= STAT_WAITS + 16'd1;
  end

endmodule

// File: tb/tb_bus_wait_state_gen.sv
// Scoreboarded bench for bus_wait_state_gen: directed test-plan sequences,
// random ALE/CS traffic against a count-based model, and a saturation run.
module tb_bus_wait_state_gen;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b0;
  logic        ALE = 1'b0;
  logic [3:0]  CS = 4'd0;
  logic        STAT_CLR = 1'b0;
  logic        READY, WAIT_ACTIVE;
  logic [2:0]  DEV_SEL;
  logic [15:0] STAT_WAITS;

  logic        s_ale = 1'b0;
  logic [3:0]  s_cs = 4'd0;
  logic        s_clr = 1'b0;
  logic        s_ready, s_wait_active;
  logic [2:0]  s_dev;
  logic [15:0] s_stat;

  always #5 CLK = ~CLK;

  bus_wait_state_gen dut (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(ALE), .CS(CS), .STAT_CLR(STAT_CLR),
    .READY(READY), .WAIT_ACTIVE(WAIT_ACTIVE), .DEV_SEL(DEV_SEL), .STAT_WAITS(STAT_WAITS)
  );

  // Large M1 count so the 16-bit statistic can be driven to its ceiling quickly.
  bus_wait_state_gen #(.WAIT_M1(65530), .WAIT_IO1(8), .CNT_WIDTH(16)) sat (
    .CLK(CLK), .RESET_N(RESET_N), .ALE(s_ale), .CS(s_cs), .STAT_CLR(s_clr),
    .READY(s_ready), .WAIT_ACTIVE(s_wait_active), .DEV_SEL(s_dev), .STAT_WAITS(s_stat)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ready;
    logic [2:0]  dev;
    logic [15:0] stat;
  } exp_t;

  exp_t q[$];
  exp_t mon_e;

  // Reference model: low-clock bookkeeping in plain integers.
  bit m_low;
  int m_left;
  bit m_armed;
  int m_pend;
  int m_dev;
  int m_stat;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int wait_of(input int d);
    case (d)
      0: return 0;
      1: return 2;
      2: return 1;
      3: return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int enc(input logic [3:0] c);
    for (int i = 0; i < 4; i++) if (c[i]) return i;
    return 4;
  endfunction

  task automatic model_reset();
    m_low = 0; m_left = 0; m_armed = 0; m_pend = 0; m_dev = 4; m_stat = 0;
  endtask

  task automatic model_edge(input bit a, input logic [3:0] c, input bit clr);
    if (a) begin
      if (m_low && m_left == 1) m_low = 0;
      m_dev   = enc(c);
      m_pend  = wait_of(m_dev);
      m_armed = 1;
    end else if (m_armed) begin
      m_armed = 0;
      if (m_pend == 0) m_low = 0;
      else begin
        m_low  = 1;
        m_left = m_pend;
      end
    end else if (m_low) begin
      if (m_stat < 65535) m_stat++;
      m_left--;
      if (m_left == 0) m_low = 0;
    end
    if (clr) m_stat = 0;
  endtask

  task automatic step(input bit a, input logic [3:0] c, input bit clr);
    ALE = a; CS = c; STAT_CLR = clr;
    @(posedge CLK);
    model_edge(a, c, clr);
    q.push_back('{ready: !m_low, dev: 3'(m_dev), stat: 16'(m_stat)});
    #1;
  endtask

  always @(negedge CLK) begin
    if (q.size() > 0) begin
      mon_e = q.pop_front();
      check("ready", int'(READY), int'(mon_e.ready));
      check("wait_active", int'(WAIT_ACTIVE), int'(!mon_e.ready));
      check("dev_sel", int'(DEV_SEL), int'(mon_e.dev));
      check("stat_waits", int'(STAT_WAITS), int'(mon_e.stat));
    end
  end

  task automatic sat_cycle(input logic [3:0] c, output int n);
    s_ale = 1'b1; s_cs = c;
    @(posedge CLK); #1;
    s_ale = 1'b0;
    @(posedge CLK); #1;
    n = 0;
    while (!s_ready && n < 70000) begin
      @(posedge CLK); #1;
      n++;
    end
    check("sat_timeout", int'(n < 70000), 1);
  endtask

  initial begin
    int n;
    model_reset();
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    RESET_N = 1'b1;
    #1;
    check("rst_ready", int'(READY), 1);
    check("rst_wait_active", int'(WAIT_ACTIVE), 0);
    check("rst_dev_sel", int'(DEV_SEL), 4);
    check("rst_stat", int'(STAT_WAITS), 0);

    // M1 cycle: two wait clocks; CS noise outside ALE must be ignored.
    step(1, 4'b0010, 0);
    repeat (4) step(0, 4'($urandom), 0);
    check("m1_dev", int'(DEV_SEL), 1);
    check("m1_stat", int'(STAT_WAITS), 2);

    step(1, 4'b0001, 0);
    repeat (3) step(0, 4'd0, 0);
    check("m0_stat", int'(STAT_WAITS), 2);
    step(1, 4'b0000, 0);
    repeat (2) step(0, 4'd0, 0);
    check("none_dev", int'(DEV_SEL), 4);
    check("none_ready", int'(READY), 1);

    // Priority then back-to-back IO1.
    step(0, 4'd0, 1);
    step(1, 4'b1100, 0);
    check("prio_dev", int'(DEV_SEL), 2);
    repeat (2) step(0, 4'd0, 0);
    step(1, 4'b1000, 0);
    repeat (5) step(0, 4'd0, 0);
    check("b2b_stat", int'(STAT_WAITS), 4);

    // Abort an IO1 cycle with an M0 capture after one wait clock.
    step(0, 4'd0, 1);
    step(1, 4'b1000, 0);
    repeat (2) step(0, 4'd0, 0);
    step(1, 4'b0001, 0);
    check("abort_hold_low", int'(READY), 0);
    step(0, 4'd0, 0);
    check("abort_ready", int'(READY), 1);
    check("abort_stat", int'(STAT_WAITS), 1);

    // Asynchronous reset in the middle of a wait window.
    step(1, 4'b1000, 0);
    repeat (2) step(0, 4'd0, 0);
    @(negedge CLK); #1;
    check("pre_rst_low", int'(READY), 0);
    RESET_N = 1'b0;
    #1;
    check("async_rst_ready", int'(READY), 1);
    check("async_rst_wait_active", int'(WAIT_ACTIVE), 0);
    check("async_rst_dev", int'(DEV_SEL), 4);
    check("async_rst_stat", int'(STAT_WAITS), 0);
    model_reset();
    @(negedge CLK);
    RESET_N = 1'b1;

    // Random traffic: held ALE, aborts, back-to-back and clears all arise here.
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 3) == 0, 4'($urandom), $urandom_range(0, 24) == 0);
    repeat (6) step(0, 4'd0, 0);
    n = 0;
    while (q.size() > 0 && n < 10) begin
      @(negedge CLK); #1;
      n++;
    end
    check("queue_drained", q.size(), 0);

    // Saturation: 65530 + 8 waits caps at 16'hFFFF.
    sat_cycle(4'b0010, n);
    check("sat_m1_len", n, 65530);
    check("sat_m1_stat", int'(s_stat), 65530);
    sat_cycle(4'b1000, n);
    check("sat_io1_len", n, 8);
    check("sat_cap", int'(s_stat), 65535);
    sat_cycle(4'b1000, n);
    check("sat_hold", int'(s_stat), 65535);

    // Clear on a wait edge beats the increment; 7 later wait edges recount.
    s_ale = 1'b1; s_cs = 4'b1000;
    @(posedge CLK); #1;
    s_ale = 1'b0;
    @(posedge CLK); #1;
    s_clr = 1'b1;
    @(posedge CLK); #1;
    s_clr = 1'b0;
    check("clr_stat", int'(s_stat), 0);
    check("clr_still_low", int'(s_ready), 0);
    n = 0;
    while (!s_ready && n < 20) begin
      @(posedge CLK); #1;
      n++;
    end
    check("clr_tail_len", n, 7);
    check("clr_recount", int'(s_stat), 7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
